fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the program memory (8-bit address in, 17-bit instruction out, combinational read). Holds the program counter and drives the memory address. Registers each fetched word into a one-entry instruction register toward decode, using a valid/ready handshake. Handles start, branch redirect, stall and halt; prog_mem is instantiated beside it, not inside it.

Parameters:
ADDR_W, 8, program-memory address / PC width
INSTR_W, 17, instruction word width
OP_W, 5, opcode field width (instruction bits [INSTR_W-1 -: OP_W])
HALT_OP, 5'b11111, opcode that stops fetching
CNT_W, 16, fetch-counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin fetching at start_addr (IDLE/HALT only)
start_addr  in  ADDR_W  first PC on start
mem_addr  out  ADDR_W  address to prog_mem; equals pc
mem_data  in  INSTR_W  instruction from prog_mem, same cycle
br_valid  in  1  branch redirect request from execute
br_addr  in  ADDR_W  redirect target
ir_data  out  INSTR_W  registered instruction to decode
ir_pc  out  ADDR_W  address ir_data was fetched from
ir_valid  out  1  ir_data valid
ir_ready  in  1  decode accepts ir_data when ir_valid & ir_ready
halted  out  1  high in HALT
fetch_cnt  out  CNT_W  instructions loaded into IR since reset, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (asynchronous, any time, including mid-fetch):
  - state=IDLE, pc=0, ir_data=0, ir_pc=0, ir_valid=0, fetch_cnt=0.
  - Outputs take these values immediately on the reset edge.
- mem_addr is pc, driven combinationally from the register. mem_data is sampled the same cycle.
- States: IDLE, RUN, HALT.
- IDLE:
  - start=1: pc<=start_addr, go to RUN.
  - br_valid is ignored; ir_valid stays 0.
- RUN, one decision per cycle in priority order:
  - 1) br_valid=1: pc<=br_addr, ir_valid<=0 (flush, even if the IR is mid-stall). No load this cycle; the new target is fetched next cycle.
  - 2) slot free (ir_valid=0 or ir_ready=1):
    - ir_data<=mem_data, ir_pc<=pc, ir_valid<=1, fetch_cnt+=1.
    - If the opcode of mem_data is HALT_OP: pc holds, go to HALT.
    - Otherwise pc<=pc+1, wrapping 2^ADDR_W-1 to 0 with no flag.
  - 3) stall (ir_valid=1, ir_ready=0): pc, ir_data, ir_pc and ir_valid all hold.
- Throughput and latency:
  - Steady state is one instruction per cycle.
  - First ir_valid appears one cycle after entering RUN.
  - Branch to ir_valid is 2 cycles.
- start in RUN is ignored.
- HALT:
  - halted=1; no new loads.
  - The halt instruction stays in the IR until accepted, then ir_valid<=0.
  - start=1: pc<=start_addr, ir_valid<=0, go to RUN.
  - br_valid=1 (takes priority over start): pc<=br_addr, ir_valid<=0, go to RUN.
- fetch_cnt: increments on every IR load; sticks at all-ones.
- Simultaneous events:
  - br_valid together with a free slot: the branch wins and the sequential word is discarded.
  - ir_ready together with br_valid: the current IR word counts as consumed and is then flushed.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (IDLE/RUN/HALT);
  - ADDR_W/INSTR_W/OP_W defaults;
  - HALT_OP and the other opcode constants, shared with decode.
- No sub-module. PC, IR and FSM stay in one module; prog_mem remains a sibling instance.

Test Plan:
- Reset → start=1, start_addr=0, ir_ready=1, ROM words 0..3 non-halt → ir_valid rises cycle 1; ir_pc=0,1,2,3 on consecutive cycles; ir_data=ROM[ir_pc]; fetch_cnt=4.
- Stall: ir_ready=0 for 3 cycles while ir_pc=2 → ir_data/ir_pc/mem_addr frozen (mem_addr=3); after release ir_pc=3 next cycle, no skipped or duplicated word.
- Branch: br_valid=1, br_addr=8'h40 while ir_valid=1 → next cycle ir_valid=0, mem_addr=8'h40; following cycle ir_pc=8'h40.
- Wrap: start_addr=8'hFE → ir_pc sequence FE, FF, 00, 01.
- Halt: ROM[5] opcode=5'b11111 → IR holds ir_pc=5; after accept ir_valid=0, halted=1, mem_addr stays 5; start with start_addr=0 resumes at 0.
- Reset mid-run: rst_n low during RUN at ir_pc=3 → ir_valid=0, mem_addr=0, fetch_cnt=0 immediately, before any clock edge; after release stays IDLE until start.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM encoding and opcode map.
// Decode imports the opcode constants from here as well.
package cpu_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 17;
    localparam int DEF_OP_W    = 5;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [DEF_OP_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [DEF_OP_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [DEF_OP_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [DEF_OP_W-1:0] OP_LD   = 5'b00100;
    localparam logic [DEF_OP_W-1:0] OP_ST   = 5'b00101;
    localparam logic [DEF_OP_W-1:0] OP_BR   = 5'b01000;
    localparam logic [DEF_OP_W-1:0] HALT_OP = 5'b11111;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses prog_mem combinationally
// and registers each fetched word into a one-entry IR toward decode.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int OP_W    = DEF_OP_W,
    parameter logic [OP_W-1:0] HALT_CODE = HALT_OP,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_addr,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [1:0]         dbg_state
);

    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic               slot_free;
    logic               is_halt;

    // Handshake: the IR word transfers on any cycle where ir_valid & ir_ready;
    // ir_valid, ir_data and ir_pc never change while ir_valid=1 and ir_ready=0,
    // except that a branch redirect (or restart from HALT) withdraws the word.
    assign slot_free = !ir_valid_q || ir_ready;
    assign is_halt   = (mem_data[INSTR_W-1 -: OP_W] == HALT_CODE);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_data_d   = ir_data_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (br_valid) begin
                    pc_d       = br_addr;
                    ir_valid_d = 1'b0;
                end else if (slot_free) begin
                    ir_data_d  = mem_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (fetch_cnt_q != {CNT_W{1'b1}}) begin
                        fetch_cnt_d = fetch_cnt_q + CNT_ONE;
                    end
                    // A halt word parks the PC on itself so a later start/branch is the only way on.
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            ST_HALT: begin
                if (br_valid) begin
                    pc_d       = br_addr;
                    ir_valid_d = 1'b0;
                    state_d    = ST_RUN;
                end else if (start) begin
                    pc_d       = start_addr;
                    ir_valid_d = 1'b0;
                    state_d    = ST_RUN;
                end else if (ir_valid_q && ir_ready) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_data_q   <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_data_q   <= ir_data_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign mem_addr  = pc_q;
    assign ir_data   = ir_data_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = (state_q == ST_HALT);
    assign fetch_cnt = fetch_cnt_q;
    assign dbg_state = state_q;

endmodule
